// File: rtl/dtc_vote_accumulator.sv
// Vote accumulator for decision-tree predictions.
// Builds a per-class histogram over a window and emits the majority class.
module dtc_vote_accumulator #(
  parameter int NUM_CLASSES = 8,
  parameter int CLS_W       = 3,
  parameter int WINDOW      = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLS_W-1:0] in_class,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_total,
  output logic             out_tie
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NUM_CLASSES];
  logic [CNT_W-1:0] samples;
  logic [CLS_W-1:0] idx;
  logic [CNT_W-1:0] best_count;
  logic [CLS_W-1:0] best_class;
  logic             best_tie;

  logic             accept;
  logic             close_win;
  logic             last_bin;
  logic [CNT_W-1:0] bin;
  logic [CNT_W-1:0] nb_count;
  logic [CLS_W-1:0] nb_class;
  logic             nb_tie;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign last_bin  = (idx == CLS_W'(NUM_CLASSES - 1));

  // A flush only closes the window if it holds at least one sample
  assign close_win =
    (accept && (samples == CNT_W'(WINDOW - 1))) ||
    (in_ready && flush && (accept || samples != '0));

  // Strict compare keeps the lowest index on equal counts
  always_comb begin
    bin      = cnt[idx];
    nb_count = best_count;
    nb_class = best_class;
    nb_tie   = best_tie;
    if (bin > best_count) begin
      nb_count = bin;
      nb_class = idx;
      nb_tie   = 1'b0;
    end else if (bin == best_count && best_count != '0) begin
      nb_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      samples    <= '0;
      idx        <= '0;
      best_count <= '0;
      best_class <= '0;
      best_tie   <= 1'b0;
      out_class  <= '0;
      out_count  <= '0;
      out_total  <= '0;
      out_tie    <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (accept) begin
            cnt[in_class] <= cnt[in_class] + CNT_W'(1);
            samples       <= samples + CNT_W'(1);
          end
          if (close_win) state <= SCAN;
        end
        SCAN: begin
          best_count <= nb_count;
          best_class <= nb_class;
          best_tie   <= nb_tie;
          idx        <= idx + CLS_W'(1);
          if (last_bin) begin
            out_class <= nb_class;
            out_count <= nb_count;
            out_total <= samples;
            out_tie   <= nb_tie;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            for (int i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
            samples    <= '0;
            idx        <= '0;
            best_count <= '0;
            best_class <= '0;
            best_tie   <= 1'b0;
            state      <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
// Directed self-checking bench for dtc_vote_accumulator.
// Drives and samples 1ns after each rising edge.
module tb_dtc_vote_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_class;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_class;
  logic [4:0] out_count;
  logic [4:0] out_total;
  logic       out_tie;

  int checks   = 0;
  int failures = 0;
  int lat;

  always #5 clk = ~clk;

  dtc_vote_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_total (out_total),
    .out_tie   (out_tie)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int c, input logic f);
    in_valid = 1'b1;
    in_class = 3'(c);
    flush    = f;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Cycles from the window-closing edge until out_valid, bounded
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic chk_res(input string tag, input int c,
                         input int cnt, input int tot, input int tie);
    chk({tag, "_class"}, out_class, c);
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_total"}, out_total, tot);
    chk({tag, "_tie"}, out_tie, tie);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_class  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk_res("rst", 0, 0, 0, 0);

    // full window of class 5
    for (int i = 0; i < 16; i++) send(5, 1'b0);
    chk("t1_in_ready_low", in_ready, 0);
    wait_out(lat);
    chk("t1_latency", lat, 9);
    chk_res("t1", 5, 16, 16, 0);
    tick();
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_out_valid_drop", out_valid, 0);

    // interleaved 6/2 tie, lowest index wins
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 6 : 2, 1'b0);
    wait_out(lat);
    chk_res("t2", 2, 8, 16, 1);
    tick();

    // short window closed by flush with the third sample
    send(1, 1'b0);
    send(4, 1'b0);
    send(1, 1'b1);
    wait_out(lat);
    chk("t3_latency", lat, 9);
    chk_res("t3", 1, 2, 3, 0);
    tick();

    // flush on an empty window is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_out_valid", out_valid, 0);
    chk("t4_in_ready", in_ready, 1);

    // back-pressure on the result
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(0, 1'b0);
    wait_out(lat);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_class = 3'((i * 3 + 1) % 8);
      flush    = i[0];
      tick();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_count", out_count, 16);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    chk_res("t5", 0, 16, 16, 0);
    out_ready = 1'b1;
    tick();
    chk("t5_in_ready_back", in_ready, 1);
    send(4, 1'b0);
    send(4, 1'b0);
    send(4, 1'b1);
    wait_out(lat);
    chk_res("t5_next", 4, 3, 3, 0);
    tick();

    // reset in the middle of SCAN
    for (int i = 0; i < 16; i++) send(6, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk_res("t6_rst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_in_ready", in_ready, 1);
    for (int i = 0; i < 16; i++) send(3, 1'b0);
    wait_out(lat);
    chk("t6_latency", lat, 9);
    chk_res("t6", 3, 16, 16, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
